// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the round-robin write arbiter.
// The arbiter takes the slave modport and the environment takes the master.
interface fifo_wr_arbiter_if #(
   parameter int num_req = 4,
   parameter int width   = 8
);
   localparam int OW = (num_req > 1) ? $clog2(num_req) : 1;

   logic [num_req-1:0]       req_i;
   logic [num_req*width-1:0] data_i;
   logic [num_req-1:0]       ack_o;
   logic [width-1:0]         fifo_din_o;
   logic                     fifo_wr_en_o;
   logic                     fifo_full_i;
   logic [OW-1:0]            owner_o;
   logic                     busy_o;

   modport slave (
      input  req_i, data_i, fifo_full_i,
      output ack_o, fifo_din_o, fifo_wr_en_o, owner_o, busy_o
   );

   modport master (
      output req_i, data_i, fifo_full_i,
      input  ack_o, fifo_din_o, fifo_wr_en_o, owner_o, busy_o
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among num_req producers.
// Each owner keeps the port for up to max_burst beats; every release costs one bubble cycle.
module fifo_wr_arbiter #(
   parameter int num_req   = 4,
   parameter int width     = 8,
   parameter int max_burst = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int OW = (num_req > 1) ? $clog2(num_req) : 1;
   localparam int CW = $clog2(max_burst + 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t        r_state, w_state_nxt;
   logic [OW-1:0] r_rr, w_rr_nxt;
   logic [OW-1:0] r_owner, w_owner_nxt;
   logic [CW-1:0] r_count, w_count_nxt;
   logic [OW-1:0] w_sel;
   logic [OW-1:0] w_found_idx;
   logic          w_found;
   logic          w_acc;
   logic          w_owner_req;
   int            w_idx;

   // The +1 wraps at num_req, which need not be a power of two.
   function automatic logic [OW-1:0] inc_wrap(input logic [OW-1:0] v);
      if (int'(v) == num_req - 1) return '0;
      return v + 1'b1;
   endfunction

   // First requester at or after the round-robin pointer.
   always_comb begin
      w_found     = 1'b0;
      w_found_idx = '0;
      w_idx       = 0;
      for (int i = 0; i < num_req; i++) begin
         w_idx = int'(r_rr) + i;
         if (w_idx >= num_req) w_idx = w_idx - num_req;
         if (!w_found && bus.req_i[OW'(w_idx)]) begin
            w_found     = 1'b1;
            w_found_idx = OW'(w_idx);
         end
      end
   end

   assign w_owner_req = bus.req_i[r_owner];

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr;
      w_owner_nxt = r_owner;
      w_count_nxt = r_count;
      w_sel       = r_owner;
      w_acc       = 1'b0;
      if (!reset_i) begin
         case (r_state)
            S_IDLE: begin
               w_sel = w_found_idx;
               if (w_found && !bus.fifo_full_i) begin
                  w_acc       = 1'b1;
                  w_owner_nxt = w_found_idx;
                  w_count_nxt = CW'(1);
                  if (max_burst == 1) w_rr_nxt = inc_wrap(w_found_idx);
                  else                w_state_nxt = S_BURST;
               end
            end
            S_BURST: begin
               if (w_owner_req && !bus.fifo_full_i && (r_count < CW'(max_burst))) begin
                  w_acc       = 1'b1;
                  w_count_nxt = r_count + 1'b1;
               end else if (!w_owner_req || (r_count == CW'(max_burst))) begin
                  // Release takes a bubble; the next grant is arbitrated from IDLE.
                  w_rr_nxt    = inc_wrap(r_owner);
                  w_count_nxt = '0;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_owner <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rr    <= w_rr_nxt;
         r_owner <= w_owner_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      bus.ack_o = '0;
      if (w_acc) bus.ack_o[w_sel] = 1'b1;
   end

   assign bus.fifo_wr_en_o = w_acc;
   assign bus.fifo_din_o   = (w_acc || (!reset_i && r_state == S_BURST)) ?
                             bus.data_i[w_sel*width +: width] : '0;
   assign bus.owner_o      = reset_i ? '0 : r_owner;
   assign bus.busy_o       = !reset_i && (r_state == S_BURST);
endmodule
